// File: rtl/agc_pkg.sv
// Shared definitions for the AGC gain search block: controller state
// encoding and the default gain / settle-counter widths.
package agc_pkg;

  localparam int AGC_GAIN_W   = 6;
  localparam int AGC_SETTLE_W = 4;

  // S_* states belong to the successive-approximation search,
  // T_* states to the +/-1 tracking loop that may follow it.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S_SETTLE = 3'd1,
    S_MEAS   = 3'd2,
    T_SETTLE = 3'd3,
    T_MEAS   = 3'd4,
    HOLD     = 3'd5
  } agc_state_e;

endpackage

// File: rtl/agc_settle_timer.sv
// Settle down-counter. A load presets the count; while counting, the
// count steps down to zero and stops there. expired flags the last cycle
// of a settle interval, so a load of N yields exactly N counting cycles.
module agc_settle_timer
  import agc_pkg::*;
#(
  parameter int SETTLE_W = AGC_SETTLE_W
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                count,
  output logic                expired
);

  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;

  // Next count: a load always wins over counting; counting stops at zero.
  always_comb begin
    // NOTE: the default comes first so no path leaves cnt_d unassigned,
    // which would otherwise infer a latch.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample the values
    // from before the edge, independent of block ordering.
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle holding count 1 is the last settle cycle; 0 covers a zero load.
  assign expired = (cnt_q <= SETTLE_W'(1));

endmodule

// File: rtl/agc_gain_search.sv
// AGC gain search controller. A start runs a successive-approximation
// search over the gain code (MSB first, one detector decision per bit,
// with a settle wait after every gain change). The result is then either
// held or, if track_en was high at completion, refined by +/-1 tracking
// steps. The applied gain is always clamped to [gain_min, gain_max];
// gain_max wins when the limits cross.
module agc_gain_search
  import agc_pkg::*;
#(
  parameter int GAIN_W   = AGC_GAIN_W,
  parameter int SETTLE_W = AGC_SETTLE_W
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                start,
  input  logic                track_en,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [GAIN_W-1:0]   gain_min,
  input  logic [GAIN_W-1:0]   gain_max,
  input  logic                meas_valid,
  input  logic                up_dn,
  output logic [GAIN_W-1:0]   gain,
  output logic                meas_req,
  output logic                busy,
  output logic                done,
  output logic                sat
);

  localparam int                PTR_W    = $clog2(GAIN_W);
  localparam int                GW1      = GAIN_W + 1;
  localparam logic [GAIN_W-1:0] MSB_ONLY = {1'b1, {(GAIN_W-1){1'b0}}};
  localparam logic [PTR_W-1:0]  PTR_TOP  = PTR_W'(GAIN_W - 1);

  agc_state_e        state_q, state_d;
  logic [GAIN_W-1:0] trial_q, trial_d;
  logic [GAIN_W-1:0] gain_q,  gain_d;
  logic [PTR_W-1:0]  ptr_q,   ptr_d;
  logic              done_q,  done_d;

  logic [PTR_W-1:0]  ptr_m1;
  logic [GAIN_W-1:0] lim_lo, lim_hi;
  logic [GAIN_W-1:0] sar_next;
  logic [GAIN_W-1:0] step_up, step_dn;
  logic              settle_zero;
  logic              timer_load, timer_count, timer_expired;
  logic              in_track;

  // Clamp a code (one bit wider, so +1 cannot wrap) into [lo, hi].
  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W:0]   x,
                                                   input logic [GAIN_W-1:0] lo,
                                                   input logic [GAIN_W-1:0] hi);
    logic [GAIN_W-1:0] r;
    if (x > {1'b0, hi}) begin
      r = hi;
    end else if (x < {1'b0, lo}) begin
      r = lo;
    end else begin
      r = x[GAIN_W-1:0];
    end
    return r;
  endfunction

  // Effective limits: a crossed pair collapses onto gain_max.
  assign lim_hi      = gain_max;
  assign lim_lo      = (gain_min > gain_max) ? gain_max : gain_min;
  assign settle_zero = (settle_cycles == '0);
  assign ptr_m1      = ptr_q - PTR_W'(1);
  assign in_track    = (state_q == T_SETTLE) || (state_q == T_MEAS);
  assign timer_count = (state_q == S_SETTLE) || (state_q == T_SETTLE);

  // SAR code after a decision: bit[ptr] follows up_dn, next lower bit trialled.
  always_comb begin
    sar_next        = trial_q;
    sar_next[ptr_q] = up_dn;
    if (ptr_q != '0) begin
      sar_next[ptr_m1] = 1'b1;
    end
  end

  // Tracking candidates: one code up or down, saturating at the limits.
  always_comb begin
    step_up = clamp_gain({1'b0, gain_q} + GW1'(1), lim_lo, lim_hi);
    if (gain_q == '0) begin
      step_dn = lim_lo;
    end else begin
      step_dn = clamp_gain({1'b0, gain_q} - GW1'(1), lim_lo, lim_hi);
    end
  end

  // Next-state and datapath update; start overrides any state and any measurement.
  always_comb begin
    state_d    = state_q;
    trial_d    = trial_q;
    gain_d     = gain_q;
    ptr_d      = ptr_q;
    done_d     = done_q;
    timer_load = 1'b0;

    if (start) begin
      trial_d    = MSB_ONLY;
      ptr_d      = PTR_TOP;
      gain_d     = clamp_gain({1'b0, MSB_ONLY}, lim_lo, lim_hi);
      done_d     = 1'b0;
      timer_load = 1'b1;
      state_d    = settle_zero ? S_MEAS : S_SETTLE;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          // Gain frozen; detector results are ignored.
        end

        S_SETTLE: begin
          if (timer_expired) begin
            state_d = S_MEAS;
          end
        end

        S_MEAS: begin
          if (meas_valid) begin
            trial_d = sar_next;
            gain_d  = clamp_gain({1'b0, sar_next}, lim_lo, lim_hi);
            if (ptr_q != '0) begin
              ptr_d      = ptr_m1;
              timer_load = 1'b1;
              state_d    = settle_zero ? S_MEAS : S_SETTLE;
            end else begin
              // Last bit decided: search complete, track_en sampled here only.
              done_d = 1'b1;
              if (track_en) begin
                timer_load = 1'b1;
                state_d    = settle_zero ? T_MEAS : T_SETTLE;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end

        T_SETTLE: begin
          if (!track_en) begin
            state_d = HOLD;
          end else if (timer_expired) begin
            state_d = T_MEAS;
          end
        end

        T_MEAS: begin
          if (!track_en) begin
            state_d = HOLD;
          end else if (meas_valid) begin
            // A saturated step leaves gain unchanged but still re-settles.
            gain_d     = up_dn ? step_up : step_dn;
            timer_load = 1'b1;
            state_d    = settle_zero ? T_MEAS : T_SETTLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Controller registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
      trial_q <= '1;
      gain_q  <= '1;
      ptr_q   <= PTR_TOP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trial_q <= trial_d;
      gain_q  <= gain_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  agc_settle_timer #(
    .SETTLE_W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .RESET    (RESET),
    .load     (timer_load),
    .load_val (settle_cycles),
    .count    (timer_count),
    .expired  (timer_expired)
  );

  assign gain     = gain_q;
  assign meas_req = (state_q == S_MEAS) || (state_q == T_MEAS);
  assign busy     = (state_q == S_SETTLE) || (state_q == S_MEAS);
  assign done     = done_q;
  assign sat      = in_track && ((gain_q == lim_lo) || (gain_q == lim_hi));

endmodule

// File: doc/agc_gain_search.md
AGC_GAIN_SEARCH -- requirements
Module: agc_gain_search

Interface
REQ-001 SHALL have parameter GAIN_W, default 6: gain code width (>=2).
REQ-002 SHALL have parameter SETTLE_W, default 4: settle counter width.
REQ-003 SHALL have port clk  input  1: single clock; all logic on posedge.
REQ-004 SHALL have port RESET  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: begin/restart a search.
REQ-006 SHALL have port track_en  input  1: after search, enter +/-1 tracking instead of holding.
REQ-007 SHALL have port settle_cycles  input  SETTLE_W: number of cycles to wait after each gain change.
REQ-008 SHALL have port gain_min  input  GAIN_W: lower clamp.
REQ-009 SHALL have port gain_max  input  GAIN_W: upper clamp.
REQ-010 SHALL have port meas_valid  input  1: detector result valid.
REQ-011 SHALL have port up_dn  input  1: qualified by meas_valid; 1 = signal low, need more gain; 0 = less gain.
REQ-012 SHALL have port gain  output  GAIN_W: registered gain code applied to the amplifier.
REQ-013 SHALL have port meas_req  output  1: high while waiting for a measurement.
REQ-014 SHALL have port busy  output  1: high during search.
REQ-015 SHALL have port done  output  1: level; high once search completes, until next start or reset.
REQ-016 SHALL have port sat  output  1: high in tracking when gain equals gain_min or gain_max.

Function
REQ-017 SHALL implement FSM states IDLE, S_SETTLE, S_MEAS, T_SETTLE, T_MEAS, HOLD.
REQ-018 SHALL perform successive approximation: on start, trial = only the MSB set, ptr = GAIN_W-1, next state S_SETTLE.
REQ-019 SHALL apply gain = clamp(trial, gain_min, gain_max), registered; if gain_min > gain_max, gain_max SHALL win.
REQ-020 SHALL load the settle counter with settle_cycles on every SETTLE entry, stay exactly settle_cycles cycles, then go to MEAS; settle_cycles = 0 SHALL go straight to MEAS.
REQ-021 SHALL assert meas_req only in S_MEAS/T_MEAS; meas_valid outside these states SHALL be ignored.
REQ-022 On meas_valid in S_MEAS, SHALL keep bit[ptr] if up_dn=1, else clear it; if ptr>0, SHALL set bit[ptr-1], decrement ptr and enter S_SETTLE.
REQ-023 On meas_valid in S_MEAS with ptr=0, SHALL decide bit 0, assert done the next cycle, and enter T_SETTLE if track_en=1, else HOLD.
REQ-024 On meas_valid in T_MEAS, SHALL step gain +1 (up_dn=1) or -1 (up_dn=0), saturating at gain_max/gain_min with no wrap, then enter T_SETTLE; a saturated no-change step SHALL still re-settle.
REQ-025 SHALL sample track_en only at search completion; deasserting it during tracking SHALL move T_SETTLE/T_MEAS to HOLD next cycle.
REQ-026 start in any state SHALL restart the search and clear done; start with simultaneous meas_valid SHALL cause start to win and the measurement to be discarded.
REQ-027 busy SHALL be 1 in S_SETTLE/S_MEAS only; in IDLE/HOLD, gain SHALL be held constant.

Reset
REQ-028 RESET SHALL force state IDLE, gain = all ones, trial = all ones, ptr = GAIN_W-1, counter = 0, meas_req = busy = done = sat = 0, overriding start, including mid-search.

Structure
REQ-029 SHALL place the state enum type and default GAIN_W/SETTLE_W constants in shared package agc_pkg.
REQ-030 SHALL instantiate the settle down-counter as sub-module agc_settle_timer (load, count, expired).

Verification (GAIN_W=6, gain_min=0, gain_max=0x3F unless stated)
REQ-031 SHALL cover: RESET asserted for 1 cycle -> gain=0x3F, meas_req=busy=done=0.
REQ-032 SHALL cover: settle_cycles=0, start, up_dn 1,0,1,1,0,0 -> gain 0x20,0x30,0x28,0x2C,0x2E,0x2D, final 0x2C, done=1, HOLD.
REQ-033 SHALL cover: settle_cycles=3 -> meas_req rises exactly 3 cycles after each gain change.
REQ-034 SHALL cover: track_en=1, gain_max=0x2D, search result 0x2C, then up_dn=1 twice -> gain 0x2D, 0x2D, sat=1.
REQ-035 SHALL cover: gain_max=0x18, start -> first presented gain 0x18 (trial 0x20).
REQ-036 SHALL cover: start with simultaneous meas_valid in S_MEAS -> measurement discarded, gain=0x20, done=0, busy=1.
